div_check_mul: RTL
==================

// Module: div_check_mul
// PURPOSE
//  Sequential shift-add multiply-accumulate that rebuilds a dividend from divider
//  outputs: A = C*B + REM. Inverse of the DIV_n_n cell (C = quotient, B = divisor,
//  REM = remainder). Sits downstream of a divider as a result-consistency checker.
//  Also usable as a plain multi-cycle multiplier (tie REM to 0).
//  Input and output use valid/ready handshakes.
// PARAMETERS
//  WIDTH   4   operand width of C, B and REM; the result A is 2*WIDTH bits wide
// PORTS
//  CLK        in   1        single clock; all state updates on the rising edge
//  RST        in   1        synchronous, active-high reset
//  IN_VALID   in   1        operands C/B/REM are valid
//  IN_READY   out  1        block can accept operands
//  C          in   WIDTH    quotient (multiplier)
//  B          in   WIDTH    divisor (multiplicand)
//  REM        in   WIDTH    remainder (addend)
//  OUT_VALID  out  1        A/ERR are valid
//  OUT_READY  in   1        consumer accepts the result
//  A          out  2*WIDTH  reconstructed dividend C*B+REM
//  ERR        out  1        inconsistent divider tuple: B==0 or REM>=B
// BEHAVIOUR
//  - Reset (RST=1 at the clock edge): state=IDLE, IN_READY=1, OUT_VALID=0, A=0, ERR=0.
//    Reset in any state abandons the operation with no output.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: IN_READY=1. On IN_VALID & IN_READY, register the operands:
//      acc=zext(REM), mcand=zext(B) to 2*WIDTH, mult=C, cnt=0, ERR=(B==0)|(REM>=B).
//      Then go to RUN.
//    RUN: IN_READY=0. Each cycle:
//      if mult[0] then acc += mcand;
//      mcand <<= 1; mult >>= 1; cnt++.
//      After exactly WIDTH RUN cycles, go to DONE.
//    DONE: OUT_VALID=1, A=acc. A and ERR are held stable while OUT_READY=0.
//      On OUT_READY, go to IDLE and drop OUT_VALID.
//  - Latency: OUT_VALID rises WIDTH+1 cycles after the accept edge.
//    Throughput: at most one operation per WIDTH+2 cycles.
//    There is no accept in the same cycle as the output is consumed; IN_READY
//    rises in the cycle after the DONE handshake.
//  - Width: the 2*WIDTH accumulator cannot overflow.
//    Max result (2^W-1)^2 + (2^W-1) = 2^2W - 2^W.
//  - ERR is informational only; A is always computed.
//    B==0 gives A=REM.
//  - IN_VALID is ignored outside IDLE. Operands may change freely after the accept.
//  - OUT_READY outside DONE has no effect.
//  - cnt width is clog2(WIDTH+1). It must not wrap; the RUN exit is at cnt==WIDTH-1.
// STRUCTURE
//  - Shared package div_pkg:
//    - state typedef {IDLE, RUN, DONE}
//    - localparam function for the cnt width (clog2(WIDTH+1))
//    - ERR encoding constants, reused by the divider-side checker
//  - One sub-module, div_check_mul_dp: datapath only (acc/mcand/mult registers and
//    adder), with load/step strobes. FSM, cnt and handshakes stay in the top.
// TESTING (WIDTH=4)
//  1. C=3, B=5, REM=2 accepted at cycle t -> OUT_VALID at t+5, A=8'h11 (17), ERR=0.
//  2. C=15, B=15, REM=14 -> A=8'hEF (239), ERR=0. Maximum operands, no overflow.
//  3. C=7, B=0, REM=3 -> A=8'h03, ERR=1. Then C=1, B=5, REM=6 -> A=8'h0B, ERR=1.
//  4. OUT_READY held low 4 cycles in DONE -> A/ERR stable, IN_READY=0,
//     new IN_VALID ignored. OUT_READY=1 -> next cycle OUT_VALID=0, IN_READY=1.
//  5. RST asserted mid-RUN (2nd step) -> next cycle IN_READY=1, OUT_VALID=0, A=0.
//     Then a fresh op C=2, B=3, REM=1 gives A=7.
//  6. Back-to-back ops with IN_VALID held high -> accepts spaced exactly 6 cycles
//     apart. Random sweep of all 4096 tuples against a C*B+REM model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divider family and its result-consistency checkers.
// Latency: n/a (types, constants and a sizing helper only).
// Backpressure: n/a.
package div_pkg;

  // Control states of the shift-add checker.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width; sized with one spare code so it never has to wrap.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // ERR encoding, shared with the divider-side checker.
  localparam logic ERR_OK  = 1'b0;  // tuple is a legal divider result
  localparam logic ERR_BAD = 1'b1;  // divisor is zero or remainder >= divisor

endpackage

// File: rtl/div_check_mul_dp.sv
// Datapath of the shift-add checker: acc/mcand/mult registers and the adder.
// Latency: one step per step strobe; operands are captured on load.
// Backpressure: none here; the controller decides when to load and step.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   load              capture rem/b/c into acc/mcand/mult
//   step              one shift-add iteration
//   c, b, rem         multiplier, multiplicand, addend
//   acc               running sum, equals c*b+rem after WIDTH steps
module div_check_mul_dp #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     rem,
  output logic [2*WIDTH-1:0]   acc
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mult;

  // Seeding acc with the remainder folds the "+REM" into the product for free.
  // acc is 2*WIDTH wide, so the largest sum 2^2W - 2^W never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mult  <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, rem};
      mcand <= {{WIDTH{1'b0}}, b};
      mult  <= c;
    end else if (step) begin
      if (mult[0]) begin
        acc <= acc + mcand;
      end
      mcand <= mcand << 1;
      mult  <= mult >> 1;
    end
  end

endmodule

// File: rtl/div_check_mul.sv
// Rebuilds a dividend A = C*B + REM from divider outputs and flags bad tuples.
// Latency: OUT_VALID in the 5th cycle after the accept cycle (WIDTH+1); one op per WIDTH+2 cycles.
// Backpressure: holds A/ERR while OUT_READY is low; IN_READY only in IDLE.
// Ports:
//   CLK, RST             clock and synchronous active-high reset
//   IN_VALID/IN_READY    operand handshake for C, B, REM
//   C, B, REM            quotient, divisor, remainder
//   OUT_VALID/OUT_READY  result handshake for A, ERR
//   A                    reconstructed dividend (2*WIDTH bits)
//   ERR                  B==0 or REM>=B (informational, A is still computed)
module div_check_mul
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     C,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     REM,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   A,
  output logic                 ERR
);

  localparam int CW = cnt_width(WIDTH);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          step;
  logic          last_step;

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign load      = IN_READY & IN_VALID;
  assign step      = (state == RUN);
  // Exit on the WIDTH-th step, i.e. while cnt still reads WIDTH-1.
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      ERR   <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            state <= RUN;
            cnt   <= '0;
            ERR   <= ((B == '0) || (REM >= B)) ? ERR_BAD : ERR_OK;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (last_step) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  div_check_mul_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk  (CLK),
    .rst  (RST),
    .load (load),
    .step (step),
    .c    (C),
    .b    (B),
    .rem  (REM),
    .acc  (A)
  );

endmodule
